// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter and access sequencer sharing one
// synchronous data memory between NCORES core datapaths.
//
// Ports:
//   clk     - system clock, rising edge
//   rst     - asynchronous active-high reset
//   REQ     - per-core access request (level)
//   WE      - per-core write enable, valid while REQ high
//   ADDR    - per-core address, core i at [i*AW +: AW]
//   WDATA   - per-core write data, core i at [i*DW +: DW]
//   GNT     - one-hot grant, held from ISSUE through COMPLETE
//   DONE    - one-cycle completion pulse to the served core
//   RDATA   - read data of the last completed read, qualified by DONE
//   MADDR   - memory address
//   MWDATA  - memory write data
//   MWE     - memory write strobe (ISSUE cycle only)
//   MRE     - memory read strobe (ISSUE cycle only)
//   MRDATA  - memory read data, valid MEM_LAT cycles after the strobe edge
module dmem_arbiter #(
  parameter int unsigned NCORES  = 4,
  parameter int unsigned AW      = 16,
  parameter int unsigned DW      = 16,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCORES-1:0]    REQ,
  input  logic [NCORES-1:0]    WE,
  input  logic [NCORES*AW-1:0] ADDR,
  input  logic [NCORES*DW-1:0] WDATA,
  output logic [NCORES-1:0]    GNT,
  output logic [NCORES-1:0]    DONE,
  output logic [DW-1:0]        RDATA,
  output logic [AW-1:0]        MADDR,
  output logic [DW-1:0]        MWDATA,
  output logic                 MWE,
  output logic                 MRE,
  input  logic [DW-1:0]        MRDATA
);

  localparam int unsigned IW        = (NCORES > 1) ? $clog2(NCORES) : 1;
  // WAIT lasts WAIT_INIT+1 = MEM_LAT-1 cycles; unused when MEM_LAT == 1
  localparam int unsigned WAIT_INIT = (MEM_LAT > 1) ? MEM_LAT - 2 : 0;
  localparam int unsigned CW        = (WAIT_INIT > 0) ? $clog2(WAIT_INIT + 1) : 1;
  localparam logic [IW-1:0] LAST_RST = IW'(NCORES - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ISSUE    = 2'd1,
    S_WAIT     = 2'd2,
    S_COMPLETE = 2'd3
  } state_t;

  state_t state, state_n;

  // Transaction bookkeeping
  logic [IW-1:0] g, g_n;          // index of the core being served
  logic          lat_we, we_n;    // latched direction of current access
  logic [IW-1:0] last, last_n;    // last served core (round-robin pointer)
  logic [CW-1:0] cnt, cnt_n;      // WAIT countdown

  // Next values of the registered outputs
  logic [NCORES-1:0] gnt_n, done_n;
  logic [DW-1:0]     rdata_n, mwdata_n;
  logic [AW-1:0]     maddr_n;
  logic              mwe_n, mre_n;

  // Per-core views of the packed address / data buses
  logic [AW-1:0] addr_a  [NCORES];
  logic [DW-1:0] wdata_a [NCORES];

  for (genvar i = 0; i < NCORES; i++) begin : g_unpack
    assign addr_a[i]  = ADDR[i*AW +: AW];
    assign wdata_a[i] = WDATA[i*DW +: DW];
  end

  // Round-robin pick: first eligible core searching upward from last+1.
  // The core currently receiving DONE is masked so it cannot be re-granted
  // on the same request it was just served for.
  logic [NCORES-1:0] elig;
  logic              found;
  logic [IW-1:0]     pick;
  int unsigned       cand;

  always_comb begin
    elig  = REQ & ~DONE;
    found = 1'b0;
    pick  = last;
    cand  = 0;
    for (int unsigned k = 1; k <= NCORES; k++) begin
      cand = (32'(last) + k) % NCORES;
      if (!found && elig[IW'(cand)]) begin
        found = 1'b1;
        pick  = IW'(cand);
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:     if (found) state_n = S_ISSUE;
      S_ISSUE:    state_n = (MEM_LAT > 1) ? S_WAIT : S_COMPLETE;
      S_WAIT:     if (cnt == '0) state_n = S_COMPLETE;
      S_COMPLETE: state_n = S_IDLE;
      default:    state_n = S_IDLE;
    endcase
  end

  // Output / datapath next values; everything is registered below so each
  // output takes the value belonging to the state being entered.
  always_comb begin
    gnt_n    = '0;
    done_n   = '0;
    mwe_n    = 1'b0;
    mre_n    = 1'b0;
    rdata_n  = RDATA;
    maddr_n  = MADDR;
    mwdata_n = MWDATA;
    g_n      = g;
    we_n     = lat_we;
    last_n   = last;
    cnt_n    = cnt;
    case (state)
      S_IDLE: begin
        if (found) begin
          g_n      = pick;
          we_n     = WE[pick];
          maddr_n  = addr_a[pick];
          mwdata_n = wdata_a[pick];
          gnt_n    = NCORES'(1) << pick;
          mwe_n    = WE[pick];
          mre_n    = ~WE[pick];
        end
      end
      S_ISSUE: begin
        gnt_n = GNT;
        cnt_n = CW'(WAIT_INIT);
      end
      S_WAIT: begin
        gnt_n = GNT;
        if (cnt != '0) cnt_n = cnt - CW'(1);
      end
      S_COMPLETE: begin
        // MRDATA is valid in this cycle; writes leave RDATA untouched
        done_n = NCORES'(1) << g;
        last_n = g;
        if (!lat_we) rdata_n = MRDATA;
      end
      default: ;
    endcase
  end

  // Output and bookkeeping registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      GNT    <= '0;
      DONE   <= '0;
      RDATA  <= '0;
      MADDR  <= '0;
      MWDATA <= '0;
      MWE    <= 1'b0;
      MRE    <= 1'b0;
      g      <= '0;
      lat_we <= 1'b0;
      last   <= LAST_RST;
      cnt    <= '0;
    end else begin
      GNT    <= gnt_n;
      DONE   <= done_n;
      RDATA  <= rdata_n;
      MADDR  <= maddr_n;
      MWDATA <= mwdata_n;
      MWE    <= mwe_n;
      MRE    <= mre_n;
      g      <= g_n;
      lat_we <= we_n;
      last   <= last_n;
      cnt    <= cnt_n;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: bench for dmem_arbiter. Instance A uses MEM_LAT=1,
// instance B uses MEM_LAT=3. Each has a small behavioural memory; a
// scoreboard queue per instance holds the expected DONE vector and RDATA.
module tb_dmem_arbiter;

  localparam int unsigned NC = 4;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;

  typedef struct {
    logic [NC-1:0] done;
    logic [DW-1:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  exp_t q_a[$];
  exp_t q_b[$];

  // ---------------- instance A signals ----------------
  logic            rst_a;
  logic [NC-1:0]   req_a, we_a, gnt_a, done_a;
  logic [NC*AW-1:0] addr_fa;
  logic [NC*DW-1:0] wdata_fa;
  logic [DW-1:0]   rdata_a, mwdata_a, mrdata_a;
  logic [AW-1:0]   maddr_a;
  logic            mwe_a, mre_a;

  // ---------------- instance B signals ----------------
  logic            rst_b;
  logic [NC-1:0]   req_b, we_b, gnt_b, done_b;
  logic [NC*AW-1:0] addr_fb;
  logic [NC*DW-1:0] wdata_fb;
  logic [DW-1:0]   rdata_b, mwdata_b, mrdata_b;
  logic [AW-1:0]   maddr_b;
  logic            mwe_b, mre_b;

  dmem_arbiter #(.NCORES(NC), .AW(AW), .DW(DW), .MEM_LAT(1)) u_dut_a (
    .clk(clk), .rst(rst_a), .REQ(req_a), .WE(we_a), .ADDR(addr_fa),
    .WDATA(wdata_fa), .GNT(gnt_a), .DONE(done_a), .RDATA(rdata_a),
    .MADDR(maddr_a), .MWDATA(mwdata_a), .MWE(mwe_a), .MRE(mre_a),
    .MRDATA(mrdata_a)
  );

  dmem_arbiter #(.NCORES(NC), .AW(AW), .DW(DW), .MEM_LAT(3)) u_dut_b (
    .clk(clk), .rst(rst_b), .REQ(req_b), .WE(we_b), .ADDR(addr_fb),
    .WDATA(wdata_fb), .GNT(gnt_b), .DONE(done_b), .RDATA(rdata_b),
    .MADDR(maddr_b), .MWDATA(mwdata_b), .MWE(mwe_b), .MRE(mre_b),
    .MRDATA(mrdata_b)
  );

  // Initial memory contents as a function of the low address byte
  function automatic logic [DW-1:0] mem_init(input logic [7:0] a);
    case (a)
      8'h40:   mem_init = 16'hBEEF;
      8'h20:   mem_init = 16'hCAFE;
      8'h30:   mem_init = 16'h5555;
      default: mem_init = {8'hA5, a};
    endcase
  endfunction

  // Memory A: latency 1, writable; non-read cycles return 0xDEAD
  logic [DW-1:0] wmem_a [256];
  logic [255:0]  wvalid_a;
  logic [DW-1:0] pipe_a;
  always @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      wvalid_a <= '0;
      pipe_a   <= 16'hDEAD;
    end else begin
      if (mwe_a) begin
        wmem_a[maddr_a[7:0]]   <= mwdata_a;
        wvalid_a[maddr_a[7:0]] <= 1'b1;
      end
      if (mre_a)
        pipe_a <= wvalid_a[maddr_a[7:0]] ? wmem_a[maddr_a[7:0]] : mem_init(maddr_a[7:0]);
      else
        pipe_a <= 16'hDEAD;
    end
  end
  assign mrdata_a = pipe_a;

  // Memory B: latency 3, read-only
  logic [DW-1:0] pipe_b [3];
  always @(posedge clk) begin
    pipe_b[0] <= mre_b ? mem_init(maddr_b[7:0]) : 16'hDEAD;
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end
  assign mrdata_b = pipe_b[2];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic nx(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_a(input int c, input logic r, input logic w,
                       input logic [AW-1:0] ad, input logic [DW-1:0] wd);
    req_a[c] = r;
    we_a[c]  = w;
    addr_fa[c*AW +: AW]  = ad;
    wdata_fa[c*DW +: DW] = wd;
  endtask

  task automatic set_b(input int c, input logic r, input logic w,
                       input logic [AW-1:0] ad, input logic [DW-1:0] wd);
    req_b[c] = r;
    we_b[c]  = w;
    addr_fb[c*AW +: AW]  = ad;
    wdata_fb[c*DW +: DW] = wd;
  endtask

  // Scoreboard monitors: pop and compare whenever a DONE pulse appears
  always @(negedge clk) begin
    if (!rst_a && done_a != '0) begin
      if (q_a.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_a_unexpected: got DONE %b expected none", done_a);
      end else begin
        exp_t e;
        e = q_a.pop_front();
        check("sb_a_done", 32'(done_a), 32'(e.done));
        check("sb_a_rdata", 32'(rdata_a), 32'(e.rdata));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_b && done_b != '0) begin
      if (q_b.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_b_unexpected: got DONE %b expected none", done_b);
      end else begin
        exp_t e;
        e = q_b.pop_front();
        check("sb_b_done", 32'(done_b), 32'(e.done));
        check("sb_b_rdata", 32'(rdata_b), 32'(e.rdata));
      end
    end
  end

  // Structural invariants every cycle
  always @(negedge clk) begin
    check("inv_a_onehot", 32'($onehot0(gnt_a)), 32'd1);
    check("inv_a_strobes", 32'(mwe_a & mre_a), 32'd0);
    check("inv_b_onehot", 32'($onehot0(gnt_b)), 32'd1);
    check("inv_b_strobes", 32'(mwe_b & mre_b), 32'd0);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected end of stimulus");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    req_a = '0; we_a = '0; addr_fa = '0; wdata_fa = '0;
    req_b = '0; we_b = '0; addr_fb = '0; wdata_fb = '0;
    nx(2);

    // Reset state
    check("rst_gnt",    32'(gnt_a),    32'd0);
    check("rst_done",   32'(done_a),   32'd0);
    check("rst_rdata",  32'(rdata_a),  32'd0);
    check("rst_maddr",  32'(maddr_a),  32'd0);
    check("rst_mwdata", 32'(mwdata_a), 32'd0);
    check("rst_mwe",    32'(mwe_a),    32'd0);
    check("rst_mre",    32'(mre_a),    32'd0);
    rst_a = 1'b0; rst_b = 1'b0;
    nx(1);

    // Single read, core 2 @0x0040
    set_a(2, 1'b1, 1'b0, 16'h0040, 16'h0000);
    q_a.push_back('{done: 4'b0100, rdata: 16'hBEEF});
    nx(1);
    check("rd_issue_mre",   32'(mre_a),   32'd1);
    check("rd_issue_mwe",   32'(mwe_a),   32'd0);
    check("rd_issue_maddr", 32'(maddr_a), 32'h0040);
    check("rd_issue_gnt",   32'(gnt_a),   32'b0100);
    nx(1);
    check("rd_cmpl_mre",  32'(mre_a),  32'd0);
    check("rd_cmpl_gnt",  32'(gnt_a),  32'b0100);
    check("rd_cmpl_done", 32'(done_a), 32'd0);
    nx(1);
    check("rd_done",       32'(done_a),  32'b0100);
    check("rd_done_gnt",   32'(gnt_a),   32'd0);
    check("rd_done_rdata", 32'(rdata_a), 32'hBEEF);
    req_a = '0;
    nx(1);

    // Single write, core 1 @0x0010 = 0x1234; RDATA must stay 0xBEEF
    set_a(1, 1'b1, 1'b1, 16'h0010, 16'h1234);
    q_a.push_back('{done: 4'b0010, rdata: 16'hBEEF});
    nx(1);
    check("wr_issue_mwe",    32'(mwe_a),    32'd1);
    check("wr_issue_mre",    32'(mre_a),    32'd0);
    check("wr_issue_maddr",  32'(maddr_a),  32'h0010);
    check("wr_issue_mwdata", 32'(mwdata_a), 32'h1234);
    check("wr_issue_gnt",    32'(gnt_a),    32'b0010);
    nx(1);
    check("wr_cmpl_mwe", 32'(mwe_a), 32'd0);
    nx(1);
    check("wr_done", 32'(done_a), 32'b0010);
    req_a = '0;
    nx(1);

    // Read back the written word through the arbiter
    set_a(1, 1'b1, 1'b0, 16'h0010, 16'h0000);
    q_a.push_back('{done: 4'b0010, rdata: 16'h1234});
    nx(3);
    check("rb_done", 32'(done_a), 32'b0010);
    req_a = '0;
    nx(1);

    // Fairness: all four request continuously from reset
    rst_a = 1'b1;
    nx(1);
    check("rst2_rdata", 32'(rdata_a), 32'd0);
    for (int c = 0; c < 4; c++) set_a(c, 1'b1, 1'b0, 16'(c), 16'h0000);
    for (int t = 0; t < 8; t++)
      q_a.push_back('{done: 4'(1 << (t % 4)), rdata: 16'hA500 + 16'(t % 4)});
    rst_a = 1'b0;
    for (int t = 0; t < 8; t++) begin
      nx(1);
      check("fair_gnt", 32'(gnt_a), 32'(1) << (t % 4));
      nx(2);
      check("fair_done", 32'(done_a), 32'(1) << (t % 4));
      if (t == 7) req_a = 4'b1001;
    end

    // Wrap: last=3, REQ=1001 -> core 0 then core 3
    q_a.push_back('{done: 4'b0001, rdata: 16'hA500});
    q_a.push_back('{done: 4'b1000, rdata: 16'hA503});
    nx(1);
    check("wrap_gnt0", 32'(gnt_a), 32'b0001);
    nx(2);
    check("wrap_done0", 32'(done_a), 32'b0001);
    req_a[0] = 1'b0;
    nx(1);
    check("wrap_gnt3", 32'(gnt_a), 32'b1000);
    nx(2);
    check("wrap_done3", 32'(done_a), 32'b1000);
    req_a = '0;
    nx(2);

    // MEM_LAT=3 read, core 0 @0x0020
    set_b(0, 1'b1, 1'b0, 16'h0020, 16'h0000);
    q_b.push_back('{done: 4'b0001, rdata: 16'hCAFE});
    nx(1);
    check("l3_issue_mre",   32'(mre_b),   32'd1);
    check("l3_issue_maddr", 32'(maddr_b), 32'h0020);
    check("l3_issue_gnt",   32'(gnt_b),   32'b0001);
    nx(1);
    check("l3_wait1_mre", 32'(mre_b), 32'd0);
    check("l3_wait1_gnt", 32'(gnt_b), 32'b0001);
    nx(1);
    check("l3_wait2_done", 32'(done_b), 32'd0);
    nx(1);
    check("l3_cmpl_gnt",  32'(gnt_b),  32'b0001);
    check("l3_cmpl_done", 32'(done_b), 32'd0);
    nx(1);
    check("l3_done",       32'(done_b),  32'b0001);
    check("l3_done_gnt",   32'(gnt_b),   32'd0);
    check("l3_done_rdata", 32'(rdata_b), 32'hCAFE);
    req_b = '0;
    nx(1);

    // Reset during WAIT aborts the transaction without a DONE
    set_b(2, 1'b1, 1'b0, 16'h0030, 16'h0000);
    nx(2);
    check("abort_pre_gnt", 32'(gnt_b), 32'b0100);
    #1 rst_b = 1'b1;
    #1;
    check("abort_gnt",   32'(gnt_b),   32'd0);
    check("abort_mre",   32'(mre_b),   32'd0);
    check("abort_mwe",   32'(mwe_b),   32'd0);
    check("abort_done",  32'(done_b),  32'd0);
    check("abort_rdata", 32'(rdata_b), 32'd0);
    req_b = '0;
    nx(1);

    // After release core 0 wins over core 2
    set_b(0, 1'b1, 1'b0, 16'h0020, 16'h0000);
    set_b(2, 1'b1, 1'b0, 16'h0030, 16'h0000);
    q_b.push_back('{done: 4'b0001, rdata: 16'hCAFE});
    q_b.push_back('{done: 4'b0100, rdata: 16'h5555});
    rst_b = 1'b0;
    nx(1);
    check("prio_gnt0", 32'(gnt_b), 32'b0001);
    nx(4);
    check("prio_done0", 32'(done_b), 32'b0001);
    req_b[0] = 1'b0;
    nx(1);
    check("prio_gnt2", 32'(gnt_b), 32'b0100);
    nx(4);
    check("prio_done2", 32'(done_b), 32'b0100);
    req_b = '0;
    nx(4);

    check("sb_a_drained", 32'(q_a.size()), 32'd0);
    check("sb_b_drained", 32'(q_b.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
